gate_chain_reducer: RTL and testbench
=====================================

// Module: gate_chain_reducer
// PURPOSE
//  Sequential, parametrised successor to the combinational AND gate chain.
//  - Reduces a LENGTH-bit operand CHUNK bits per clock with a selectable op: AND, OR, XOR or NAND.
//  - Also reports the index of the first bit that decides the result (the "chain break").
//  - Sits between a valid/ready producer and a valid/ready consumer.
// PARAMETERS
//  LENGTH      32  operand width in bits, >=1
//  CHUNK       8   bits reduced per cycle, 1..LENGTH
//  EARLY_EXIT  1   1: stop as soon as the result is decided (AND/OR/NAND); 0: always run all chunks
//  derived: STEPS = ceil(LENGTH/CHUNK); IDXW = $clog2(LENGTH+1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       synchronous reset, active low
//  in_valid    in   1       operand offered
//  in_ready    out  1       block can accept an operand
//  in_data     in   LENGTH  operand
//  in_mode     in   2       00 AND, 01 OR, 10 XOR, 11 NAND
//  out_valid   out  1       result available
//  out_ready   in   1       consumer accepts result
//  out_result  out  1       reduction result
//  out_idx     out  IDXW    first deciding bit index, or LENGTH if none
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state IDLE; in_ready=1; out_valid=0; out_result=0; out_idx=0.
//   - Abandons any operation in flight, including one that is mid-RUN or in DONE.
//  FSM states:
//   IDLE: in_ready=1. If in_valid, then at the edge:
//    - capture data and mode;
//    - acc <= identity (1 for AND/NAND, 0 for OR/XOR); k <= 0; found <= 0;
//    - go to RUN.
//   RUN: in_ready=0. Each edge processes bits [k*CHUNK +: CHUNK], LSB first.
//    - acc_next = acc op chunk (NAND uses AND here).
//    - Stop condition: AND/NAND, the first 0 bit; OR, the first 1 bit; XOR, none.
//    - On the first stop bit seen, latch idx = k*CHUNK + lowest local position.
//    - Go to DONE when k == STEPS-1, or when EARLY_EXIT=1 and a stop bit lies in this chunk.
//    - Otherwise k <= k+1.
//   DONE: out_valid=1.
//    - out_result = acc (inverted for NAND); out_idx = latched idx, or LENGTH if none found.
//    - out_result and out_idx stay stable while out_valid=1 && out_ready=0.
//    - On out_valid && out_ready: go to IDLE and clear out_valid next cycle.
//  Latency: out_valid rises STEPS cycles after the accept edge.
//   - With EARLY_EXIT=1 and a stop bit in chunk j, it rises j+1 cycles after the accept edge.
//  Throughput: minimum one operation per latency+2 cycles.
//   - There is no bypass from DONE to accept: in_ready rises the cycle after the output handshake.
//  Width rule: when LENGTH is not a multiple of CHUNK, the top chunk is padded with identity bits.
//   - Padding never sets idx and never changes the result.
//  in_valid seen while not in IDLE is ignored.
//   - in_data/in_mode are sampled only at the accept edge; later changes do not affect the operation.
//  XOR: out_idx is always LENGTH.
//  Mode 11 (NAND): idx rule as AND; only out_result is inverted.
// STRUCTURE
//  Package gate_chain_pkg:
//   - mode localparams MODE_AND/OR/XOR/NAND;
//   - FSM state encoding ST_IDLE/ST_RUN/ST_DONE;
//   - identity-bit function per mode.
//  Sub-module chunk_reduce (combinational, parameter CHUNK):
//   - inputs (acc_in, bits, mode);
//   - outputs (acc_out, stop_found, stop_pos).
//  Top level holds the FSM, counter k, the capture registers and the output registers.
// TESTING (LENGTH=32, CHUNK=8, EARLY_EXIT=1 unless stated)
//  1. AND, 32'hFFFF_FFFF, out_ready=1:
//     result 1, idx 32, out_valid 4 cycles after accept.
//     Repeat in NAND: result 0, idx 32.
//  2. AND, 32'hFFFF_EFFF:
//     result 0, idx 12, out_valid 2 cycles after accept.
//     With EARLY_EXIT=0: same values after 4 cycles.
//  3. XOR, 32'h0000_0007: result 1, idx 32, 4 cycles.
//     XOR, 32'h0000_0003: result 0.
//  4. OR, 32'h0 with out_ready held low 5 cycles:
//     - out_valid stays 1; result 0 and idx 32 are stable; in_ready stays 0;
//     - in_valid pulses during this time are ignored;
//     - after the handshake, in_ready=1 next cycle.
//  5. Reset: rst_n=0 for one edge during RUN (k=1).
//     - Next cycle: out_valid=0, in_ready=1, out_result=0, out_idx=0.
//     - A following AND 32'hFFFF_FFFF operation completes correctly.
//  6. LENGTH=12, CHUNK=8, AND, 12'hFFF:
//     result 1, idx 12, 2 cycles (padding is inert).
//     12'h7FF: result 0, idx 11, 2 cycles.

Source files
------------

// File: rtl/gate_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_chain_pkg
// Description : Shared mode codes, FSM encoding and identity-bit helper for
//               the sequential gate chain reducer.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_chain_pkg;

    // Reduction operation selector
    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Neutral element of the reduction: 1 for AND-like ops, 0 for OR/XOR
    function automatic logic identity_bit(input logic [1:0] mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_chain_reducer_chunk_reduce.sv
`default_nettype none
// ============================================================================
// Module      : chunk_reduce
// Description : Combinational reduction of one CHUNK-wide slice into the
//               running accumulator, plus lowest "stop" bit detection.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_reduce
    import gate_chain_pkg::*;
#(
    parameter int CHUNK = 8,
    localparam int POSW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic             acc_i,
    input  logic [CHUNK-1:0] bits_i,
    input  logic [1:0]       mode_i,
    output logic             acc_o,
    output logic             stop_found_o,
    output logic [POSW-1:0]  stop_pos_o
);

    // A stop bit is the value that decides the result: 1 for OR, 0 for AND/NAND
    logic             w_stop_val;
    logic [CHUNK-1:0] w_stop;

    assign w_stop_val = (mode_i == MODE_OR);

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_stop
        assign w_stop[gi] = (mode_i != MODE_XOR) && (bits_i[gi] == w_stop_val);
    end

    assign stop_found_o = |w_stop;

    // Lowest set position wins: scan from MSB down so the last hit is the lowest
    always_comb begin
        stop_pos_o = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (w_stop[i]) begin
                stop_pos_o = POSW'(i);
            end
        end
    end

    // Fold the slice into the accumulator; NAND accumulates as AND
    always_comb begin
        acc_o = acc_i;
        case (mode_i)
            MODE_OR:  acc_o = acc_i | (|bits_i);
            MODE_XOR: acc_o = acc_i ^ (^bits_i);
            default:  acc_o = acc_i & (&bits_i);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gate_chain_reducer.sv
`default_nettype none
// ============================================================================
// Module      : gate_chain_reducer
// Description : Valid/ready wrapped, chunk-serial AND/OR/XOR/NAND reducer
//               that also reports the first deciding bit index.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_chain_reducer
    import gate_chain_pkg::*;
#(
    parameter int LENGTH     = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1,
    localparam int IDXW      = $clog2(LENGTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [LENGTH-1:0] in_data_i,
    input  logic [1:0]        in_mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_result_o,
    output logic [IDXW-1:0]   out_idx_o
);

    localparam int STEPS = (LENGTH + CHUNK - 1) / CHUNK;
    localparam int PADW  = STEPS * CHUNK;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int POSW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    localparam logic [IDXW-1:0] C_LEN   = IDXW'(LENGTH);
    localparam logic [IDXW-1:0] C_CHUNK = IDXW'(CHUNK);
    localparam logic [KW-1:0]   C_KLAST = KW'(STEPS - 1);

    logic [1:0]      state_q, state_d;
    logic [PADW-1:0] data_q;
    logic [1:0]      mode_q;
    logic            acc_q;
    logic [KW-1:0]   k_q;
    logic [IDXW-1:0] base_q;
    logic            found_q;
    logic [IDXW-1:0] idx_q;
    logic            res_q;
    logic [IDXW-1:0] oidx_q;

    logic [PADW-1:0] w_padded;
    logic            w_acc_out;
    logic            w_stop_found;
    logic [POSW-1:0] w_stop_pos;
    logic [IDXW-1:0] w_hit_idx;
    logic            w_last;

    // Top chunk padding uses the identity bit so it can never stop or alter acc
    if (PADW > LENGTH) begin : g_pad
        assign w_padded = {{(PADW - LENGTH){identity_bit(in_mode_i)}}, in_data_i};
    end else begin : g_nopad
        assign w_padded = in_data_i;
    end

    chunk_reduce #(
        .CHUNK(CHUNK)
    ) u_chunk_reduce (
        .acc_i       (acc_q),
        .bits_i      (data_q[CHUNK-1:0]),
        .mode_i      (mode_q),
        .acc_o       (w_acc_out),
        .stop_found_o(w_stop_found),
        .stop_pos_o  (w_stop_pos)
    );

    assign w_hit_idx = base_q + IDXW'(w_stop_pos);
    assign w_last    = (k_q == C_KLAST) || ((EARLY_EXIT != 0) && w_stop_found);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step through chunks, wait for consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid_i)  state_d = ST_RUN;
            ST_RUN:  if (w_last)      state_d = ST_DONE;
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_o  = 1'b1;
            ST_DONE: out_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture on accept, shift one chunk per RUN cycle, latch result on exit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            mode_q  <= MODE_AND;
            acc_q   <= 1'b0;
            k_q     <= '0;
            base_q  <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= 1'b0;
            oidx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        data_q  <= w_padded;
                        mode_q  <= in_mode_i;
                        acc_q   <= identity_bit(in_mode_i);
                        k_q     <= '0;
                        base_q  <= '0;
                        found_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q  <= w_acc_out;
                    data_q <= data_q >> CHUNK;
                    k_q    <= k_q + KW'(1);
                    base_q <= base_q + C_CHUNK;
                    if (w_stop_found && !found_q) begin
                        found_q <= 1'b1;
                        idx_q   <= w_hit_idx;
                    end
                    if (w_last) begin
                        res_q <= (mode_q == MODE_NAND) ? ~w_acc_out : w_acc_out;
                        if (found_q) begin
                            oidx_q <= idx_q;
                        end else if (w_stop_found) begin
                            oidx_q <= w_hit_idx;
                        end else begin
                            oidx_q <= C_LEN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_result_o = res_q;
    assign out_idx_o    = oidx_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_chain_reducer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_chain_reducer
// Description : Self-checking bench for gate_chain_reducer: three instances
//               (32/8 early exit, 32/8 full run, 12/8 padded) driven with
//               directed vectors and checked against a bit-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_chain_reducer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [11:0] d2 = '0;
    logic [1:0]  m0 = '0, m1 = '0, m2 = '0;
    wire  [2:0]  ir, ov, ores;
    wire  [5:0]  x0, x1;
    wire  [3:0]  x2;

    int checks = 0;
    int failures = 0;
    bit [2:0] armed = '0;
    bit [2:0] exp_res = '0;
    int exp_idx [3];

    always #5 clk = ~clk;

    gate_chain_reducer #(.LENGTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .in_data_i(d0), .in_mode_i(m0), .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
        .out_result_o(ores[0]), .out_idx_o(x0));

    gate_chain_reducer #(.LENGTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .in_data_i(d1), .in_mode_i(m1), .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
        .out_result_o(ores[1]), .out_idx_o(x1));

    gate_chain_reducer #(.LENGTH(12), .CHUNK(8), .EARLY_EXIT(1)) u_dut_pad (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .in_data_i(d2), .in_mode_i(m2), .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
        .out_result_o(ores[2]), .out_idx_o(x2));

    function automatic int get_idx(input int d);
        case (d)
            0:       return int'(x0);
            1:       return int'(x1);
            default: return int'(x2);
        endcase
    endfunction

    task automatic set_in(input int d, input logic [31:0] data, input logic [1:0] mode);
        case (d)
            0:       begin d0 = data;       m0 = mode; end
            1:       begin d1 = data;       m1 = mode; end
            default: begin d2 = data[11:0]; m2 = mode; end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: scan bits LSB first, find the first deciding bit, derive everything from it
    function automatic void model(input int len, input int chunk, input int ee,
                                  input logic [31:0] data, input logic [1:0] mode,
                                  output bit res, output int idx, output int lat);
        int first = -1;
        bit par = 1'b0;
        int steps = (len + chunk - 1) / chunk;
        for (int i = 0; i < len; i++) begin
            par ^= data[i];
            if (first < 0 && mode != 2'b10 && data[i] == (mode == 2'b01)) first = i;
        end
        case (mode)
            2'b00:   res = (first < 0);
            2'b01:   res = (first >= 0);
            2'b10:   res = par;
            default: res = (first >= 0);
        endcase
        idx = (first < 0) ? len : first;
        lat = (ee != 0 && first >= 0) ? first / chunk + 1 : steps;
    endfunction

    // Whenever a result is presented, it must match the model's prediction
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n && armed[d] && ov[d]) begin
                checks++;
                if (ores[d] !== exp_res[d] || get_idx(d) != exp_idx[d]) begin
                    failures++;
                    $display("FAIL cmp_dut%0d result=%0d idx=%0d required result=%0d idx=%0d",
                             d, ores[d], get_idx(d), exp_res[d], exp_idx[d]);
                end
            end
        end
    end

    task automatic run_op(input int d, input logic [31:0] data, input logic [1:0] mode,
                          input int hold, input bit lit_res, input int lit_idx,
                          input int lit_lat, input string name);
        int  lens [3] = '{32, 32, 12};
        int  ees  [3] = '{1, 0, 1};
        bit  mres;
        int  midx, mlat, t, lat;
        model(lens[d], 8, ees[d], data, mode, mres, midx, mlat);
        chk({name, "_model_res"}, int'(mres), int'(lit_res));
        chk({name, "_model_idx"}, midx, lit_idx);
        chk({name, "_model_lat"}, mlat, lit_lat);
        exp_res[d] = mres;
        exp_idx[d] = midx;
        armed[d]   = 1'b1;
        @(negedge clk);
        ordy[d] = (hold == 0);
        set_in(d, data, mode);
        iv[d] = 1'b1;
        t = 0;
        while (!ir[d] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            chk({name, "_ready_timeout"}, 0, 1);
            iv[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        set_in(d, ~data, ~mode);
        lat = 0;
        while (!ov[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, "_latency"}, lat, lit_lat);
        chk({name, "_result"}, int'(ores[d]), int'(lit_res));
        chk({name, "_idx"}, get_idx(d), lit_idx);
        for (int i = 0; i < hold; i++) begin
            chk({name, "_hold_valid"}, int'(ov[d]), 1);
            chk({name, "_hold_ready"}, int'(ir[d]), 0);
            set_in(d, 32'hFFFF_FFFF, 2'b00);
            iv[d] = i[0];
            @(posedge clk);
            @(negedge clk);
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        chk({name, "_pre_hs_valid"}, int'(ov[d]), 1);
        @(posedge clk);
        @(negedge clk);
        armed[d] = 1'b0;
        chk({name, "_post_hs_valid"}, int'(ov[d]), 0);
        chk({name, "_post_hs_ready"}, int'(ir[d]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_idx = '{0, 0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid",  int'(ov[0]), 0);
        chk("reset_ready",  int'(ir[0]), 1);
        chk("reset_result", int'(ores[0]), 0);
        chk("reset_idx",    get_idx(0), 0);
        rst_n = 1'b1;

        run_op(0, 32'hFFFF_FFFF, 2'b00, 0, 1'b1, 32, 4, "and_ones");
        run_op(0, 32'hFFFF_FFFF, 2'b11, 0, 1'b0, 32, 4, "nand_ones");
        run_op(0, 32'hFFFF_EFFF, 2'b00, 0, 1'b0, 12, 2, "and_bit12");
        run_op(0, 32'hFFFF_EFFF, 2'b11, 0, 1'b1, 12, 2, "nand_bit12");
        run_op(0, 32'hFFFF_FFFE, 2'b00, 0, 1'b0, 0,  1, "and_bit0");
        run_op(0, 32'h0000_0007, 2'b10, 0, 1'b1, 32, 4, "xor_7");
        run_op(0, 32'h0000_0003, 2'b10, 0, 1'b0, 32, 4, "xor_3");
        run_op(0, 32'h0000_0100, 2'b01, 0, 1'b1, 8,  2, "or_bit8");
        run_op(0, 32'h0000_0000, 2'b01, 5, 1'b0, 32, 4, "or_zero_stall");
        run_op(1, 32'hFFFF_EFFF, 2'b00, 0, 1'b0, 12, 4, "full_and_bit12");
        run_op(2, 32'h0000_0FFF, 2'b00, 0, 1'b1, 12, 2, "pad_and_fff");
        run_op(2, 32'h0000_07FF, 2'b00, 0, 1'b0, 11, 2, "pad_and_7ff");

        // Reset in the middle of RUN (after the first chunk has been consumed)
        @(negedge clk);
        ordy[0] = 1'b1;
        set_in(0, 32'hFFFF_FFFF, 2'b00);
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset_valid",  int'(ov[0]), 0);
        chk("midrun_reset_ready",  int'(ir[0]), 1);
        chk("midrun_reset_result", int'(ores[0]), 0);
        chk("midrun_reset_idx",    get_idx(0), 0);

        run_op(0, 32'hFFFF_FFFF, 2'b00, 0, 1'b1, 32, 4, "after_reset_and");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
